// File: rtl/univ_shift_register.sv
// univ_shift_register: universal shift register with load/shift/rotate/asr and self-timed burst rotate
module univ_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             serial_in_r,
  input  logic             serial_in_l,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
  output logic             done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] rem, rem_n;
  logic [WIDTH-1:0] q_n, rotr;
  logic done_n;
  assign rotr = {parallel_out[0], parallel_out[WIDTH-1:1]};
  always_comb begin
    state_n = state;
    rem_n = rem;
    q_n = parallel_out;
    done_n = 1'b0;
    if (state == RUN) begin
      q_n = rotr;
      rem_n = rem - 1'b1;
      state_n = (rem == CNT_W'(1)) ? IDLE : RUN;
      done_n = (rem == CNT_W'(1));
    end else if (en) begin
      case (mode)
        3'b001: q_n = parallel_in;
        3'b010: q_n = {parallel_out[WIDTH-2:0], serial_in_r};
        3'b011: q_n = {serial_in_l, parallel_out[WIDTH-1:1]};
        3'b100: q_n = {parallel_out[WIDTH-2:0], parallel_out[WIDTH-1]};
        3'b101: q_n = rotr;
        3'b110: q_n = {parallel_out[WIDTH-1], parallel_out[WIDTH-1:1]};
        3'b111: begin
          done_n = (count == '0);
          rem_n = count;
          state_n = (count == '0) ? IDLE : RUN;
        end
        default: q_n = parallel_out;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      rem <= '0;
      parallel_out <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      rem <= rem_n;
      parallel_out <= q_n;
      done <= done_n;
    end
  end
  assign busy = (state == RUN);
  assign serial_out_l = parallel_out[WIDTH-1];
  assign serial_out_r = parallel_out[0];
endmodule

// File: tb/tb_univ_shift_register.sv
// tb_univ_shift_register: directed scoreboard bench for univ_shift_register
module tb_univ_shift_register;
  logic clk = 1'b0;
  logic reset, en, serial_in_r, serial_in_l, serial_out_l, serial_out_r, busy, done;
  logic [2:0] mode;
  logic [7:0] parallel_in, count, parallel_out;
  typedef struct {
    logic [7:0] po;
    logic b;
    logic d;
    string tag;
  } exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  univ_shift_register #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .parallel_in(parallel_in),
    .serial_in_r(serial_in_r), .serial_in_l(serial_in_l), .count(count),
    .parallel_out(parallel_out), .serial_out_l(serial_out_l), .serial_out_r(serial_out_r),
    .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  task automatic drive(input logic e, input logic [2:0] m, input logic [7:0] pi,
                       input logic sr, input logic sl, input logic [7:0] c);
    en = e;
    mode = m;
    parallel_in = pi;
    serial_in_r = sr;
    serial_in_l = sl;
    count = c;
  endtask
  task automatic push(input logic [7:0] po, input logic b, input logic d, input string tag);
    exp_t x;
    x.po = po;
    x.b = b;
    x.d = d;
    x.tag = tag;
    sb.push_back(x);
  endtask
  task automatic tick();
    exp_t x;
    @(posedge clk);
    #1;
    x = sb.pop_front();
    checks++;
    assert (parallel_out === x.po) else begin
      errors++;
      $error("FAIL %s parallel_out got %h expected %h", x.tag, parallel_out, x.po);
    end
    checks++;
    assert (busy === x.b) else begin
      errors++;
      $error("FAIL %s busy got %b expected %b", x.tag, busy, x.b);
    end
    checks++;
    assert (done === x.d) else begin
      errors++;
      $error("FAIL %s done got %b expected %b", x.tag, done, x.d);
    end
    checks++;
    assert ({serial_out_l, serial_out_r} === {x.po[7], x.po[0]}) else begin
      errors++;
      $error("FAIL %s serial_out got %b%b expected %b%b", x.tag, serial_out_l, serial_out_r, x.po[7], x.po[0]);
    end
  endtask
  initial begin
    logic [7:0] v;
    reset = 1'b0;
    drive(1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 8'h05);
    #1;
    push(8'h00, 1'b0, 1'b0, "reset0");
    tick();
    drive(1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
    push(8'h00, 1'b0, 1'b0, "reset1");
    tick();
    reset = 1'b1;
    drive(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 8'h00); push(8'hA5, 1'b0, 1'b0, "load_a5"); tick();
    drive(1'b1, 3'b010, 8'h00, 1'b1, 1'b0, 8'h00); push(8'h4B, 1'b0, 1'b0, "shl"); tick();
    drive(1'b1, 3'b011, 8'h00, 1'b1, 1'b0, 8'h00); push(8'h25, 1'b0, 1'b0, "shr"); tick();
    drive(1'b1, 3'b001, 8'hA5, 1'b0, 1'b0, 8'h00); push(8'hA5, 1'b0, 1'b0, "reload_a5"); tick();
    drive(1'b1, 3'b100, 8'h00, 1'b0, 1'b0, 8'h00); push(8'h4B, 1'b0, 1'b0, "rotl"); tick();
    drive(1'b1, 3'b101, 8'h00, 1'b0, 1'b0, 8'h00); push(8'hA5, 1'b0, 1'b0, "rotr"); tick();
    drive(1'b1, 3'b001, 8'h96, 1'b0, 1'b0, 8'h00); push(8'h96, 1'b0, 1'b0, "load_96"); tick();
    drive(1'b1, 3'b110, 8'h00, 1'b0, 1'b0, 8'h00); push(8'hCB, 1'b0, 1'b0, "asr"); tick();
    drive(1'b0, 3'b001, 8'hFF, 1'b1, 1'b1, 8'h00); push(8'hCB, 1'b0, 1'b0, "en0_hold"); tick();
    drive(1'b1, 3'b000, 8'hFF, 1'b1, 1'b1, 8'h00); push(8'hCB, 1'b0, 1'b0, "mode_hold"); tick();
    drive(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h00); push(8'h81, 1'b0, 1'b0, "load_81"); tick();
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'd3); push(8'h81, 1'b1, 1'b0, "b3_e0"); tick();
    drive(1'b1, 3'b001, 8'hFF, 1'b1, 1'b1, 8'd7);
    push(8'hC0, 1'b1, 1'b0, "b3_e1"); tick();
    push(8'h60, 1'b1, 1'b0, "b3_e2"); tick();
    push(8'h30, 1'b0, 1'b1, "b3_e3"); tick();
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00); push(8'h30, 1'b0, 1'b0, "b3_after"); tick();
    drive(1'b1, 3'b001, 8'h3C, 1'b0, 1'b0, 8'h00); push(8'h3C, 1'b0, 1'b0, "load_3c"); tick();
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'd0); push(8'h3C, 1'b0, 1'b1, "b0_done"); tick();
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00); push(8'h3C, 1'b0, 1'b0, "b0_after"); tick();
    drive(1'b1, 3'b001, 8'h01, 1'b0, 1'b0, 8'h00); push(8'h01, 1'b0, 1'b0, "load_01"); tick();
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'd9); push(8'h01, 1'b1, 1'b0, "b9_e0"); tick();
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00);
    v = 8'h01;
    for (int i = 1; i <= 9; i++) begin
      v = {v[0], v[7:1]};
      push(v, i < 9, i == 9, $sformatf("b9_e%0d", i));
      tick();
    end
    drive(1'b1, 3'b001, 8'h5A, 1'b0, 1'b0, 8'h00); push(8'h5A, 1'b0, 1'b0, "b2b_load"); tick();
    drive(1'b1, 3'b001, 8'h81, 1'b0, 1'b0, 8'h00); push(8'h81, 1'b0, 1'b0, "load_81b"); tick();
    drive(1'b1, 3'b111, 8'h00, 1'b0, 1'b0, 8'd5); push(8'h81, 1'b1, 1'b0, "b5_e0"); tick();
    drive(1'b0, 3'b000, 8'h00, 1'b0, 1'b0, 8'h00);
    push(8'hC0, 1'b1, 1'b0, "b5_e1"); tick();
    push(8'h60, 1'b1, 1'b0, "b5_e2"); tick();
    reset = 1'b0;
    push(8'h00, 1'b0, 1'b0, "midrst"); tick();
    reset = 1'b1;
    push(8'h00, 1'b0, 1'b0, "midrst_nodone"); tick();
    push(8'h00, 1'b0, 1'b0, "midrst_idle"); tick();
    drive(1'b1, 3'b001, 8'h11, 1'b0, 1'b0, 8'h00); push(8'h11, 1'b0, 1'b0, "load_11"); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/univ_shift_register.md
# univ_shift_register

Parametrised universal shift register, the successor to the fixed 4-bit parallel-in/parallel-out register. It adds hold, parallel load, logical shifts, rotates and an arithmetic shift, plus serial ports for cascading. A self-timed burst-rotate mode, with busy/done handshake, rotates the word N positions without per-cycle control. It sits in the datapath as a general-purpose staging/alignment register.

## Interface
- WIDTH, 8: register width in bits, ≥ 2
- CNT_W, 8: width of the burst count input
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- en  input  1  command strobe; mode is sampled only when en=1 and busy=0
- mode  input  3  operation select (see Operation)
- parallel_in  input  WIDTH  load data
- serial_in_r  input  1  bit shifted into LSB on shift-left
- serial_in_l  input  1  bit shifted into MSB on shift-right
- count  input  CNT_W  burst rotate count, sampled with the burst command
- parallel_out  output  WIDTH  register contents
- serial_out_l  output  1  parallel_out[WIDTH-1], combinational from register
- serial_out_r  output  1  parallel_out[0], combinational from register
- busy  output  1  burst in progress
- done  output  1  one-cycle pulse at burst completion

## Operation
- Reset (reset=0 at an edge): parallel_out=0, busy=0, done=0, internal remaining count=0. Reset has priority over everything, including an active burst, which is abandoned.
- Idle commands (en=1, busy=0). Single-cycle, result visible after the sampling edge:
  - 000 hold
  - 001 load parallel_in
  - 010 shift left: {q[WIDTH-2:0], serial_in_r}
  - 011 shift right: {serial_in_l, q[WIDTH-1:1]}
  - 100 rotate left: {q[WIDTH-2:0], q[WIDTH-1]}
  - 101 rotate right: {q[0], q[WIDTH-1:1]}
  - 110 arithmetic shift right: {q[WIDTH-1], q[WIDTH-1:1]}
  - 111 burst rotate right by count
- en=0: hold.
- Burst FSM states:
  - IDLE → on mode=111 with count≠0: load remaining=count, go to RUN, busy=1.
  - IDLE → on mode=111 with count=0: stay in IDLE; done=1 next cycle; register unchanged.
  - RUN: each edge rotates right once and decrements remaining.
  - RUN → IDLE on the edge where remaining goes 1→0: busy=0, done=1.
- While busy=1, en, mode, count, parallel_in and serial inputs are ignored. Commands issued during a burst are dropped, not queued.
- count ≥ WIDTH is legal: performs exactly count single rotations, so the net rotation is count mod WIDTH.
- done is high only for the cycle after completion. A new command is accepted in the same cycle done is high, because busy is already 0.

## Timing
- Single-cycle ops: latency 1 clock from the sampling edge to parallel_out.
- Burst, accepted at edge E0:
  - busy=1 from E0 until E(count).
  - Rotations occur at edges E1..E(count).
  - At E(count): busy=0 and done=1, together with the final register value.
  - done returns to 0 at E(count+1).
- Burst with count=0: done=1 for one cycle after E0; busy never asserts.
- Serial outputs follow parallel_out with no added latency.
- All outputs are registered except serial_out_l and serial_out_r.

## Test plan
- Reset with random inputs, reset=0 for 2 cycles: parallel_out=0x00, busy=0, done=0. Release, then load 0xA5: parallel_out=0xA5 one edge later.
- From 0xA5:
  - shl with serial_in_r=1 → 0x4B
  - shr with serial_in_l=0 → 0x25
  - rotl → 0x4B
  - rotr → 0xA5
  - asr on 0x96 → 0xCB
  - en=0 → holds the value
- Load 0x81, burst count=3: busy high exactly 3 cycles; done pulses once at the final edge; parallel_out=0x30. Commands (load 0xFF) issued during busy are ignored.
- Burst count=0 on 0x3C: no busy; done pulses 1 cycle; parallel_out stays 0x3C. Burst count=9 on 0x01: after 9 cycles parallel_out=0x80, done=1.
- Reset asserted mid-burst (cycle 2 of count=5): parallel_out=0, busy=0, no done pulse. A subsequent load 0x11 is accepted normally.
- Back-to-back: new load issued in the done cycle is accepted; parallel_out shows the loaded value one edge later.
